oka_gf2_mul_seq: RTL and testbench

- Parametrised, sequential, one-level overlap-free Karatsuba carry-less multiplier over GF(2), for W-bit operands.
- Reuses a single shared (W/2)x(W/2) carry-less multiplier across three cycles instead of three parallel half-width multipliers.
- Optional mode reduces the product modulo the field polynomial x^W + POLY.
- Sits between the operand source and the field-arithmetic datapath behind valid/ready handshakes on both sides.

---
 rtl/oka_gf2_mul_seq_if.sv | 24 ++
 rtl/oka_gf2_mul_seq.sv | 156 +++++++++++++++
 tb/tb_oka_gf2_mul_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oka_gf2_mul_seq_if.sv
// Operand/result handshake bundle for the sequential Karatsuba GF(2) multiplier.
// The master side is the operand producer and result consumer.
interface oka_gf2_mul_seq_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           reduce;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-2:0] y;

    modport master (
        output in_valid, a, b, reduce, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a, b, reduce, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/oka_gf2_mul_seq.sv
// Sequential one-level Karatsuba carry-less multiplier over GF(2); one shared
// half-width multiplier is time-multiplexed over three cycles, optional field reduction.
module oka_gf2_clmul #(
    parameter int N = 8
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-2:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (y[i]) p[i +: N] = p[i +: N] ^ x;
        end
    end
endmodule

module oka_gf2_mul_seq #(
    parameter int           W    = 16,
    parameter logic [W-1:0] POLY = 16'h100B
) (
    input  logic              clk,
    input  logic              rst,
    oka_gf2_mul_seq_if.slave  bus
);
    localparam int H  = W / 2;
    localparam int PW = 2 * W - 1;
    localparam int ZW = 2 * H - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL0, S_MUL1, S_MUL2, S_COMB, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic          reduce_q, reduce_d;
    logic [ZW-1:0] z0_q, z0_d, z1_q, z1_d, z2_q, z2_d;
    logic [PW-1:0] y_q, y_d;

    logic          accept;
    logic [H-1:0]  mul_x, mul_y;
    logic [ZW-1:0] mul_p;
    logic [ZW-1:0] z_mid;
    logic [PW-1:0] prod, prod_red;

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            reduce_q <= 1'b0;
            z0_q     <= '0;
            z1_q     <= '0;
            z2_q     <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            reduce_q <= reduce_d;
            z0_q     <= z0_d;
            z1_q     <= z1_d;
            z2_q     <= z2_d;
            y_q      <= y_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = S_MUL0;
            S_MUL0:  state_d = S_MUL1;
            S_MUL1:  state_d = S_MUL2;
            S_MUL2:  state_d = S_COMB;
            S_COMB:  state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
    end

    assign accept = (state_q == S_IDLE) && bus.in_valid;
    assign bus.y  = y_q;

    // Operands come from the latched registers only, so input churn after accept is harmless.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            S_MUL0: begin
                mul_x = a_q[H-1:0];
                mul_y = b_q[H-1:0];
            end
            S_MUL1: begin
                mul_x = a_q[H-1:0] ^ a_q[W-1:H];
                mul_y = b_q[H-1:0] ^ b_q[W-1:H];
            end
            S_MUL2: begin
                mul_x = a_q[W-1:H];
                mul_y = b_q[W-1:H];
            end
            default: ;
        endcase
    end

    oka_gf2_clmul #(.N(H)) u_clmul (
        .x (mul_x),
        .y (mul_y),
        .p (mul_p)
    );

    // Karatsuba recombination; the middle term drops z0 and z2 out of z1.
    assign z_mid = z0_q ^ z1_q ^ z2_q;
    assign prod  = PW'(z0_q) ^ (PW'(z_mid) << H) ^ (PW'(z2_q) << W);

    // Fold from the top: each set bit k >= W is replaced by POLY at k-W.
    always_comb begin
        prod_red = prod;
        for (int k = PW - 1; k >= W; k--) begin
            if (prod_red[k]) begin
                prod_red[k]         = 1'b0;
                prod_red[k-W +: W]  = prod_red[k-W +: W] ^ POLY;
            end
        end
        prod_red[PW-1:W] = '0;
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        reduce_d = reduce_q;
        z0_d     = z0_q;
        z1_d     = z1_q;
        z2_d     = z2_q;
        y_d      = y_q;
        if (accept) begin
            a_d      = bus.a;
            b_d      = bus.b;
            reduce_d = bus.reduce;
        end
        case (state_q)
            S_MUL0:  z0_d = mul_p;
            S_MUL1:  z1_d = mul_p;
            S_MUL2:  z2_d = mul_p;
            S_COMB:  y_d  = reduce_q ? prod_red : prod;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_oka_gf2_mul_seq.sv
// Directed and random checks of oka_gf2_mul_seq at W=16 (default poly) and W=8 (AES poly).
module tb_oka_gf2_mul_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oka_gf2_mul_seq_if #(.W(16)) bus16 ();
    oka_gf2_mul_seq_if #(.W(8))  bus8 ();

    oka_gf2_mul_seq #(.W(16), .POLY(16'h100B)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    oka_gf2_mul_seq #(.W(8),  .POLY(8'h1B))    dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: schoolbook product, or bitwise multiply-and-reduce (Horner form) when red=1.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input int w, input logic [15:0] poly, input bit red);
        logic [31:0] p;
        logic [15:0] r, mask;
        bit msb;
        p = '0;
        r = '0;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        if (!red) begin
            for (int i = 0; i < w; i++) if (b[i]) p = p ^ (32'(a) << i);
        end else begin
            for (int i = w - 1; i >= 0; i--) begin
                msb = r[w-1];
                r = (r << 1) & mask;
                if (msb) r = r ^ poly;
                if (b[i]) r = r ^ a;
            end
            p = 32'(r);
        end
        return p;
    endfunction

    // One operation on the W=16 instance; returns at the negedge where out_valid is first seen.
    task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input bit red,
                            output logic [30:0] yv, output int edges, output bit busy_ok);
        @(negedge clk);
        bus16.in_valid = 1'b1;
        bus16.a = a;
        bus16.b = b;
        bus16.reduce = red;
        bus16.out_ready = 1'b0;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        bus16.a = ~a;
        bus16.b = 16'h5A5A;
        bus16.reduce = ~red;
        busy_ok = 1'b1;
        while (!bus16.out_valid && edges < 20) begin
            if (bus16.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        yv = bus16.y;
    endtask

    task automatic handshake16();
        bus16.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus16.out_ready = 1'b0;
    endtask

    task automatic check_op16(input string name, input logic [15:0] a, input logic [15:0] b,
                              input bit red, input logic [30:0] exp);
        logic [30:0] yv;
        int edges;
        bit busy_ok;
        run_op16(a, b, red, yv, edges, busy_ok);
        n_cmp++;
        if (yv !== exp) begin
            n_bad++;
            $display("FAIL %s_y: got %h expected %h", name, yv, exp);
        end
        n_cmp++;
        if (edges != 5) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d edges expected 5", name, edges);
        end
        n_cmp++;
        if (!busy_ok) begin
            n_bad++;
            $display("FAIL %s_busy_ready: in_ready got 1 expected 0 while busy", name);
        end
        handshake16();
        n_cmp++;
        if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b expected 0/1", name,
                     bus16.out_valid, bus16.in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.reduce = 1'b0; bus16.out_ready = 1'b0;
        bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.reduce = 1'b0;  bus8.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.y !== 31'h0) begin
            n_bad++;
            $display("FAIL reset16: in_ready=%b out_valid=%b y=%h expected 1/0/0",
                     bus16.in_ready, bus16.out_valid, bus16.y);
        end
        n_cmp++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.y !== 15'h0) begin
            n_bad++;
            $display("FAIL reset8: in_ready=%b out_valid=%b y=%h expected 1/0/0",
                     bus8.in_ready, bus8.out_valid, bus8.y);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        check_op16("basic", 16'h0003, 16'h0003, 1'b0, 31'h00000005);
    endtask

    task automatic test_full_ones();
        check_op16("ones", 16'hFFFF, 16'hFFFF, 1'b0, 31'h55555555);
        check_op16("top", 16'h8000, 16'h8000, 1'b0, 31'h40000000);
    endtask

    task automatic test_reduction();
        check_op16("red_x16", 16'h8000, 16'h0002, 1'b1, 31'h0000100B);
        check_op16("red_x30", 16'h8000, 16'h8000, 1'b1, 31'h00008EFA);
    endtask

    task automatic test_backpressure();
        logic [30:0] yv;
        int edges;
        bit busy_ok, stable, quiet;
        run_op16(16'h0003, 16'h0005, 1'b0, yv, edges, busy_ok);
        n_cmp++;
        if (yv !== 31'h0000000F) begin
            n_bad++;
            $display("FAIL bp_y: got %h expected %h", yv, 31'h0000000F);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus16.in_valid = 1'b1;
            bus16.a = 16'hFFFF;
            bus16.b = 16'hFFFF;
            @(posedge clk);
            @(negedge clk);
            if (bus16.out_valid !== 1'b1 || bus16.y !== 31'h0000000F || bus16.in_ready !== 1'b0)
                stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
            n_bad++;
            $display("FAIL bp_hold: out_valid=%b y=%h in_ready=%b expected 1/%h/0",
                     bus16.out_valid, bus16.y, bus16.in_ready, 31'h0000000F);
        end
        bus16.in_valid = 1'b0;
        handshake16();
        n_cmp++;
        if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1 || bus16.y !== 31'h0000000F) begin
            n_bad++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b y=%h expected 0/1/%h",
                     bus16.out_valid, bus16.in_ready, bus16.y, 31'h0000000F);
        end
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL bp_no_second: out_valid=%b in_ready=%b expected 0/1",
                     bus16.out_valid, bus16.in_ready);
        end
    endtask

    task automatic test_reset_midop();
        bit quiet;
        @(negedge clk);
        bus16.in_valid = 1'b1;
        bus16.a = 16'h00FF;
        bus16.b = 16'h0F0F;
        bus16.reduce = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus16.in_valid = 1'b0;
        n_cmp++;
        if (bus16.out_valid !== 1'b0 || bus16.y !== 31'h0 || bus16.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_state: out_valid=%b y=%h in_ready=%b expected 0/0/1",
                     bus16.out_valid, bus16.y, bus16.in_ready);
        end
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus16.out_valid !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL midrst_no_result: out_valid got 1 expected 0");
        end
    endtask

    // Streams n random operations with in_valid and out_ready held high.
    task automatic test_back_to_back(input int w, input int n);
        logic [31:0] exp_q[$];
        logic [15:0] mask, poly, ra, rb;
        logic [31:0] yv, exp;
        bit rr, take, rdy, vld;
        int acc, got, last, cyc;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        poly = (w == 16) ? 16'h100B : 16'h001B;
        acc = 0; got = 0; last = -1; cyc = 0;
        @(negedge clk);
        ra = 16'($urandom) & mask;
        rb = 16'($urandom) & mask;
        rr = 1'($urandom_range(0, 1));
        if (w == 16) begin
            bus16.a = ra; bus16.b = rb; bus16.reduce = rr; bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
        end else begin
            bus8.a = ra[7:0]; bus8.b = rb[7:0]; bus8.reduce = rr; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
        end
        while (got < n && cyc < n * 6 + 50) begin
            rdy = (w == 16) ? bus16.in_ready : bus8.in_ready;
            vld = (w == 16) ? bus16.out_valid : bus8.out_valid;
            yv  = (w == 16) ? 32'(bus16.y) : 32'(bus8.y);
            take = rdy && (acc < n);
            if (take) begin
                exp_q.push_back(ref_mul(ra, rb, w, poly, rr));
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != 6) begin
                        n_bad++;
                        $display("FAIL b2b%0d_interval: got %0d cycles expected 6", w, cyc - last);
                    end
                end
                last = cyc;
                acc++;
            end
            if (vld) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                n_cmp++;
                if (yv !== exp) begin
                    n_bad++;
                    $display("FAIL b2b%0d_y[%0d]: got %h expected %h", w, got, yv, exp);
                end
                got++;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (take) begin
                ra = 16'($urandom) & mask;
                rb = 16'($urandom) & mask;
                rr = 1'($urandom_range(0, 1));
                if (w == 16) begin
                    bus16.a = ra; bus16.b = rb; bus16.reduce = rr; bus16.in_valid = (acc < n);
                end else begin
                    bus8.a = ra[7:0]; bus8.b = rb[7:0]; bus8.reduce = rr; bus8.in_valid = (acc < n);
                end
            end
        end
        n_cmp++;
        if (got != n) begin
            n_bad++;
            $display("FAIL b2b%0d_timeout: got %0d results expected %0d", w, got, n);
        end
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
        bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_ones();
        test_reduction();
        test_backpressure();
        test_reset_midop();
        test_back_to_back(16, 1000);
        test_back_to_back(8, 1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
